// File: rtl/dds_mixer_core.sv
// Multi-channel DDS core: per-channel phase accumulators and waveform selection,
// scaled and summed, optionally mixed with an external operand, saturated to offset-binary.

module sine_lookup (
  input  logic [7:0] i_idx,
  output logic [7:0] o_sample
);

  // Quarter wave of round(127 * sin(2*pi*k/256)) for k = 0..64.
  localparam logic [6:0] QUARTER [0:64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,  7'd25,  7'd28,
    7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,  7'd49,  7'd51,  7'd54,  7'd57,
    7'd60,  7'd63,  7'd65,  7'd68,  7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,
    7'd85,  7'd88,  7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116, 7'd117, 7'd118,
    7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124, 7'd125, 7'd125, 7'd126, 7'd126,
    7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  logic [6:0] w_addr;
  logic [6:0] w_mag;

  always_comb begin
    w_addr   = i_idx[6] ? (7'd64 - {1'b0, i_idx[5:0]}) : {1'b0, i_idx[5:0]};
    w_mag    = QUARTER[w_addr];
    o_sample = i_idx[7] ? (8'd0 - {1'b0, w_mag}) : {1'b0, w_mag};
  end

endmodule

module dds_mixer_core #(
  parameter  int NCH     = 2,
  parameter  int PHASE_W = 16,
  parameter  int AMP_W   = 8,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [1:0]         cfg_sel,
  input  logic [PHASE_W-1:0] cfg_data,
  input  logic               mix_en,
  input  logic [7:0]         mix_in,
  output logic [7:0]         dac_out,
  output logic               dac_valid,
  output logic               sat_flag
);

  localparam int PROD_W = 9 + AMP_W;
  localparam int SUM_W  = 8 + CH_W + 1;
  localparam int MIX_W  = SUM_W + 8;
  localparam int M_W    = SUM_W + 1;

  logic [PHASE_W-1:0] r_ftw  [NCH];
  logic [PHASE_W-1:0] r_poff [NCH];
  logic [PHASE_W-1:0] r_acc  [NCH];
  logic [AMP_W-1:0]   r_amp  [NCH];
  logic [1:0]         r_mode [NCH];

  logic [7:0]         r_s1_idx  [NCH];
  logic [1:0]         r_s1_mode [NCH];
  logic [AMP_W-1:0]   r_s1_amp  [NCH];
  logic [7:0]         r_s2_wave [NCH];
  logic [AMP_W-1:0]   r_s2_amp  [NCH];
  logic [7:0]         r_s3_term [NCH];
  logic [M_W-1:0]     r_s4_m;
  logic               r_s1_vld, r_s2_vld, r_s3_vld, r_s4_vld;

  logic [7:0]         w_idx   [NCH];
  logic [7:0]         w_sine  [NCH];
  logic [6:0]         w_tri   [NCH];
  logic [7:0]         w_wave  [NCH];
  logic [PROD_W-1:0]  w_prod  [NCH];
  logic [SUM_W-1:0]   w_sum;
  logic [MIX_W-1:0]   w_mix_prod;
  logic [M_W-8:0]     w_hi;
  logic               w_clip;
  logic [7:0]         w_sat;

  // Config registers and accumulators. A control-register clear is written after the
  // tick update so the later non-blocking assignment wins when both land together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        r_ftw[c]  <= '0;
        r_poff[c] <= '0;
        r_acc[c]  <= '0;
        r_amp[c]  <= '0;
        r_mode[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (tick) r_acc[c] <= r_acc[c] + r_ftw[c];
        if (cfg_we && (int'(cfg_ch) == c)) begin
          case (cfg_sel)
            2'd0: r_ftw[c]  <= cfg_data;
            2'd1: r_poff[c] <= cfg_data;
            2'd2: r_amp[c]  <= cfg_data[AMP_W-1:0];
            default: begin
              r_mode[c] <= cfg_data[1:0];
              if (cfg_data[2]) r_acc[c] <= '0;
            end
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_sine
    sine_lookup u_sine (
      .i_idx    (r_s1_idx[g]),
      .o_sample (w_sine[g])
    );
  end

  // NOTE: always_comb uses blocking assignments with every output given a value on
  // every path, so the running sum below builds combinationally without a latch.
  always_comb begin
    w_sum = '0;
    for (int c = 0; c < NCH; c++) begin
      w_idx[c] = 8'((r_acc[c] + r_poff[c]) >> (PHASE_W - 8));
      w_tri[c] = r_s1_idx[c][7] ? ~r_s1_idx[c][6:0] : r_s1_idx[c][6:0];
      case (r_s1_mode[c])
        2'd0:    w_wave[c] = w_sine[c];
        2'd1:    w_wave[c] = r_s1_idx[c][7] ? 8'h81 : 8'h7F;
        2'd2:    w_wave[c] = {~r_s1_idx[c][7], r_s1_idx[c][6:0]};
        default: w_wave[c] = {~w_tri[c][6], w_tri[c][5:0], 1'b0};
      endcase
      w_prod[c] = PROD_W'($signed(r_s2_wave[c])) * PROD_W'($signed({1'b0, r_s2_amp[c]}));
      w_sum     = w_sum + {{(SUM_W-8){r_s3_term[c][7]}}, r_s3_term[c]};
    end
    w_mix_prod = MIX_W'($signed(w_sum)) * MIX_W'($signed(mix_in));
    w_hi       = r_s4_m[M_W-1:7];
    w_clip     = ~((&w_hi) | ~(|w_hi));
    w_sat      = w_clip ? (r_s4_m[M_W-1] ? 8'h80 : 8'h7F) : r_s4_m[7:0];
  end

  // NOTE: datapath stage registers carry no reset; only the valid chain and the
  // visible outputs need a defined value after reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      r_s1_idx[c]  <= w_idx[c];
      r_s1_mode[c] <= r_mode[c];
      r_s1_amp[c]  <= r_amp[c];
      r_s2_wave[c] <= w_wave[c];
      r_s2_amp[c]  <= r_s1_amp[c];
      // Bits above AMP_W of the product are the floored >>> AMP_W result.
      r_s3_term[c] <= w_prod[c][AMP_W +: 8];
    end
    r_s4_m <= mix_en ? w_mix_prod[MIX_W-1:7] : {w_sum[SUM_W-1], w_sum};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s3_vld  <= 1'b0;
      r_s4_vld  <= 1'b0;
      dac_valid <= 1'b0;
      dac_out   <= 8'h80;
      sat_flag  <= 1'b0;
    end else begin
      r_s1_vld  <= tick;
      r_s2_vld  <= r_s1_vld;
      r_s3_vld  <= r_s2_vld;
      r_s4_vld  <= r_s3_vld;
      dac_valid <= r_s4_vld;
      if (r_s4_vld) begin
        dac_out  <= {~w_sat[7], w_sat[6:0]};
        sat_flag <= w_clip;
      end
    end
  end

endmodule

// File: tb/tb_dds_mixer_core.sv
// Scoreboard bench for dds_mixer_core: a real-arithmetic reference model predicts each
// sample at tick time; a monitor pops and compares whenever dac_valid is seen.

module tb_dds_mixer_core;

  localparam int NCH     = 2;
  localparam int PHASE_W = 16;
  localparam int AMP_W   = 8;
  localparam int CH_W    = 1;
  localparam int LAT     = 5;
  localparam real PI     = 3.141592653589793;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               tick = 1'b0;
  logic               cfg_we = 1'b0;
  logic [CH_W-1:0]    cfg_ch = '0;
  logic [1:0]         cfg_sel = '0;
  logic [PHASE_W-1:0] cfg_data = '0;
  logic               mix_en = 1'b0;
  logic [7:0]         mix_in = '0;
  logic [7:0]         dac_out;
  logic               dac_valid;
  logic               sat_flag;

  dds_mixer_core #(.NCH(NCH), .PHASE_W(PHASE_W), .AMP_W(AMP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .mix_en    (mix_en),
    .mix_in    (mix_in),
    .dac_out   (dac_out),
    .dac_valid (dac_valid),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int out;
    bit sat;
    int due;
  } exp_t;

  exp_t exp_q[$];

  int m_ftw  [NCH];
  int m_poff [NCH];
  int m_acc  [NCH];
  int m_amp  [NCH];
  int m_mode [NCH];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_ftw[c] = 0; m_poff[c] = 0; m_acc[c] = 0; m_amp[c] = 0; m_mode[c] = 0;
    end
  endtask

  function automatic int sine_ref(input int p);
    real r;
    r = 127.0 * $sin(2.0 * PI * real'(p) / 256.0);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  function automatic int wave_ref(input int mode, input int p);
    case (mode)
      0: return sine_ref(p);
      1: return (p >= 128) ? -127 : 127;
      2: return p - 128;
      default: return (p < 128) ? (2 * p - 128) : (2 * (255 - p) - 128);
    endcase
  endfunction

  task automatic model_tick();
    int sum, m, s, p;
    exp_t e;
    sum = 0;
    for (int c = 0; c < NCH; c++) begin
      p = ((m_acc[c] + m_poff[c]) % 65536) / 256;
      sum += (wave_ref(m_mode[c], p) * m_amp[c]) >>> AMP_W;
    end
    m = mix_en ? ((sum * int'($signed(mix_in))) >>> 7) : sum;
    s = (m > 127) ? 127 : ((m < -128) ? -128 : m);
    e.out = s + 128;
    e.sat = (m != s);
    e.due = cyc + LAT;
    exp_q.push_back(e);
    for (int c = 0; c < NCH; c++) m_acc[c] = (m_acc[c] + m_ftw[c]) % 65536;
  endtask

  task automatic model_write(input int ch, input int sel, input int data);
    if (ch >= NCH) return;
    case (sel)
      0: m_ftw[ch] = data;
      1: m_poff[ch] = data;
      2: m_amp[ch] = data % 256;
      default: begin
        m_mode[ch] = data % 4;
        if ((data & 4) != 0) m_acc[ch] = 0;
      end
    endcase
  endtask

  // Drives one cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic issue(input bit tk, input bit we, input int ch, input int sel, input int data);
    tick     = tk;
    cfg_we   = we;
    cfg_ch   = CH_W'(ch);
    cfg_sel  = 2'(sel);
    cfg_data = PHASE_W'(data);
    if (tk) model_tick();
    if (we) model_write(ch, sel, data);
    @(posedge clk); #1;
    tick   = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic wr(input int ch, input int sel, input int data);
    issue(1'b0, 1'b1, ch, sel, data);
  endtask

  task automatic tk();
    issue(1'b1, 1'b0, 0, 0, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset(input int ncyc);
    rst  = 1'b1;
    tick = 1'b1;
    exp_q.delete();
    model_reset();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check("reset_dac_out", int'(dac_out), 8'h80);
      check("reset_valid", int'(dac_valid), 0);
      @(posedge clk); #1;
    end
    rst  = 1'b0;
    tick = 1'b0;
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      check("post_reset_valid", int'(dac_valid), 0);
      check("post_reset_dac_out", int'(dac_out), 8'h80);
      @(posedge clk); #1;
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (dac_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", int'(dac_valid), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("latency", cyc, mon_e.due);
        check("dac_out", int'(dac_out), mon_e.out);
        check("sat_flag", int'(sat_flag), int'(mon_e.sat));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset(3);

    // Square on ch0 at half-rate step, ch1 silent: alternating +126 / -127.
    wr(0, 3, 1); wr(0, 2, 255); wr(0, 0, 16'h8000);
    for (int i = 0; i < 8; i++) tk();
    drain();

    // Mid-stream reset kills in-flight samples.
    for (int i = 0; i < 3; i++) tk();
    do_reset(2);

    // Saturation: both channels saw at p = 0xFF.
    for (int c = 0; c < NCH; c++) begin
      wr(c, 3, 2 | 4); wr(c, 2, 255); wr(c, 0, 0); wr(c, 1, 16'hFF00);
    end
    tk();
    drain();

    // Mix: ch0 square +127, ch1 silent, mix_in = -64 then mix off.
    wr(0, 3, 1 | 4); wr(0, 1, 0); wr(1, 2, 0);
    mix_en = 1'b1; mix_in = 8'hC0;
    tk(); drain();
    mix_en = 1'b0;
    tk(); drain();

    // Triangle at p = 0x40 and p = 0xC0.
    wr(0, 3, 3 | 4); wr(0, 1, 16'h4000);
    tk(); drain();
    wr(0, 1, 16'hC000);
    tk(); drain();

    // Sine sweep over all 256 indices.
    wr(0, 3, 0 | 4); wr(0, 1, 0); wr(0, 0, 16'h0100);
    for (int i = 0; i < 256; i++) tk();
    drain();

    // Coincident clear + tick, then coincident FTW write + tick.
    wr(0, 3, 2); wr(0, 0, 16'h1234); wr(0, 1, 16'h3000);
    for (int i = 0; i < 3; i++) tk();
    issue(1'b1, 1'b1, 0, 3, 2 | 4);
    tk();
    issue(1'b1, 1'b1, 0, 0, 16'h0800);
    tk(); tk();
    drain();

    // Randomized traffic with coincident config writes, mix fixed per burst.
    for (int b = 0; b < 4; b++) begin
      mix_en = 1'($urandom_range(0, 1));
      mix_in = 8'($urandom);
      for (int c = 0; c < NCH; c++) wr(c, 2, int'($urandom_range(128, 255)));
      for (int i = 0; i < 80; i++) begin
        issue(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 3) == 0),
              int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 65535)));
      end
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dds_mixer_core.md
# dds_mixer_core

Multi-channel direct digital synthesis core for the R2R DAC output path. Each channel runs its own phase accumulator, picks a waveform (sine, square, saw or triangle), applies a phase offset and an amplitude. It replaces the single fixed-phase sine/mixer path. Channels are summed, optionally mixed with an external signed operand, saturated, and driven out as offset-binary samples.

## Interface

Parameters:
- NCH, 2: number of channels (1..8); CH_W = max(1, clog2(NCH)).
- PHASE_W, 16: phase accumulator, tuning word and offset width (≥ 8).
- AMP_W, 8: unsigned amplitude width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  sample strobe; each assertion advances every accumulator and launches one sample.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  CH_W  target channel; writes with cfg_ch ≥ NCH are ignored.
- cfg_sel  in  2  register select: 0 = FTW, 1 = phase offset, 2 = amplitude (low AMP_W bits), 3 = control (bits [1:0] mode, bit 2 clear accumulator).
- cfg_data  in  PHASE_W  write data.
- mix_en  in  1  enable external mix.
- mix_in  in  8  signed mix operand.
- dac_out  out  8  offset-binary sample.
- dac_valid  out  1  one-cycle pulse per produced sample.
- sat_flag  out  1  set with dac_valid when the sample clipped.

## Operation

- Per-channel registers are ftw, poff, amp and mode (0 sine, 1 square, 2 saw, 3 triangle). On reset all are 0 and every accumulator is 0.
- Accumulator update on tick: acc[c] <= acc[c] + ftw[c] mod 2^PHASE_W.
- Index: p = (acc[c] + poff[c]) mod 2^PHASE_W, top 8 bits, using the pre-update acc value.
- Waveforms, all signed 8-bit:
  - sine: the existing sine_lookup module, one instance per channel.
  - square: p[7] ? −127 : +127.
  - saw: {~p[7], p[6:0]}.
  - triangle: t = p[7] ? ~p[6:0] : p[6:0]; sample = {t,1'b0} − 128, giving the range −128..126.
- Scaling: term = (sample × amp) >>> AMP_W. The product is signed×unsigned, shifted arithmetically, which floors.
- Sum: sum of all terms, signed, width 8 + CH_W + 1, no overflow.
- Mix: if mix_en, m = (sum × mix_in) >>> 7, otherwise m = sum. mix_in is sampled in the mix stage.
- Output: sat = clamp(m, −128, 127); dac_out = sat + 128, i.e. sat with its MSB inverted. sat_flag = (m ≠ sat).
- Config write semantics:
  - Writes land at the clock edge and affect the next tick only.
  - A write coincident with a tick leaves that tick using the old values.
  - An FTW write does not disturb acc.
  - Control bit 2 is self-clearing: acc[c] <= 0. If a clear coincides with a tick, the clear wins and the tick's sample still uses the old acc.
- dac_out and sat_flag hold their last values between valid pulses.

## Timing

- The pipeline is fully pipelined, with a valid bit per stage. tick may be asserted every cycle.
- Stages, with tick sampled at edge T:
  - S1: index registered at T.
  - S2: waveform registered at T+1.
  - S3: scaled terms at T+2.
  - S4: sum and mix at T+3.
  - S5: saturation and output at T+4.
- dac_valid is high during the cycle after edge T+4, so latency is 5 cycles.
- Reset values: dac_out = 0x80 (midscale), dac_valid = 0, sat_flag = 0, all stage valids 0.
- Asserting rst mid-stream kills all in-flight samples; no dac_valid appears for ticks before reset.
- The first tick after release behaves as if it came from a fresh power-up.

## Test plan

1. Reset check: assert rst with tick active. dac_out = 0x80, dac_valid = 0 throughout reset; no valid pulse within 5 cycles after release without a new tick.
2. Square with latency:
   - Setup: ch0 mode 1, amp 255, ftw 0x8000; ch1 amp 0; tick every cycle.
   - dac_valid first rises exactly 5 cycles after the first tick.
   - dac_out alternates 0xFE (126) and 0x01 (−127), sat_flag = 0.
3. Saturation:
   - Setup: both channels saw, amp 255, ftw 0, poff 0xFF00; one tick.
   - Each term is 126, sum 252, so dac_out = 0xFF, sat_flag = 1.
4. Mix:
   - Setup: ch0 square +127, amp 255; ch1 amp 0; mix_en = 1, mix_in = −64.
   - m = 126 × −64 >>> 7 = −63, so dac_out = 0x41.
   - With mix_en = 0 the output returns to 0xFE.
5. Triangle and sine:
   - Triangle, amp 255, poff 0x4000 gives 0x80; poff 0xC000 gives 0x7E.
   - Sine, amp 255, ftw 0x0100 over 256 ticks: output matches the sine_lookup model through the same scaling.
6. Coincident events:
   - A clear and a tick in the same cycle: the next tick samples p = poff.
   - An FTW write coincident with a tick: the old step is applied once, then the new step.
